// File: rtl/spmv_mem_pkg.sv
// Shared defaults and response-entry layout for the SpMV memory model.
// A response entry is packed as {tag, data}: tag in the upper TAG_W bits and data in the
// lower DATA_W bits. The top module and its FIFO both use this ordering.
package spmv_mem_pkg;

  localparam int unsigned DefAddrW       = 48;
  localparam int unsigned DefDataW       = 64;
  localparam int unsigned DefTagW        = 3;
  localparam int unsigned DefLatency     = 16;
  localparam int unsigned DefMemWords    = 4096;
  localparam int unsigned DefRspDepth    = 32;
  localparam int unsigned DefStallMargin = 4;

  typedef struct packed {
    logic [DefTagW-1:0]  tag;
    logic [DefDataW-1:0] data;
  } rsp_entry_t;

  // Width of one packed {tag, data} response entry.
  function automatic int unsigned rsp_entry_w(input int unsigned tag_w, input int unsigned data_w);
    return tag_w + data_w;
  endfunction

endpackage

// File: rtl/spmv_sync_fifo.sv
// Synchronous FIFO with a combinational head (rd_data shows the oldest entry while not empty).
// Ports:
//   clk, rst          - clock and synchronous active-high reset (clears pointers only)
//   wr_en, wr_data    - push an entry; caller never pushes into a full FIFO unless popping
//   rd_en, rd_data    - pop the head; rd_data is valid whenever empty is low
//   full, empty, count- occupancy status
module spmv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[PtrW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rptr_q[PtrW-1:0]];
  assign count   = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (count == (PtrW + 1)'(DEPTH));

endmodule

// File: rtl/spmv_mem_model.sv
// Behavioural memory model for an SpMV engine: word-addressed backing store, fixed-latency
// tagged loads returned in order through a response FIFO, stores with no response.
// Ports:
//   clk, rst                      - sole clock, synchronous active-high reset
//   req_mem_ld / req_mem_st       - load / store request (exactly one high to be accepted)
//   req_mem_addr                  - byte address (must be 8-byte aligned and in range)
//   req_mem_d_or_tag              - store data, or load tag in the low TAG_W bits
//   req_mem_stall                 - registered hint: too many loads outstanding
//   rsp_mem_push/_tag/_q          - response strobe, tag and data (zero when not pushing)
//   rsp_mem_stall                 - consumer backpressure
//   err                           - sticky protocol/overflow error
//   ld_count / st_count           - accepted load / store counters (wrap at 2^32)
module spmv_mem_model
  import spmv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned TAG_W        = DefTagW,
  parameter int unsigned LATENCY      = DefLatency,
  parameter int unsigned MEM_WORDS    = DefMemWords,
  parameter int unsigned RSP_DEPTH    = DefRspDepth,
  parameter int unsigned STALL_MARGIN = DefStallMargin
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_mem_ld,
  input  logic              req_mem_st,
  input  logic [ADDR_W-1:0] req_mem_addr,
  input  logic [DATA_W-1:0] req_mem_d_or_tag,
  output logic              req_mem_stall,
  output logic              rsp_mem_push,
  output logic [TAG_W-1:0]  rsp_mem_tag,
  output logic [DATA_W-1:0] rsp_mem_q,
  input  logic              rsp_mem_stall,
  output logic              err,
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count
);

  localparam int unsigned EntW = rsp_entry_w(TAG_W, DATA_W);
  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned OutW = $clog2(LATENCY + RSP_DEPTH + 1);

  logic              dual_req, ld_acc, st_acc, addr_bad;
  logic [ADDR_W-4:0] word_idx;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic              dl_vld_q [LATENCY];
  logic [EntW-1:0]   dl_ent_q [LATENCY];

  logic              tail_vld, pop, fifo_wr, drop;
  logic              fifo_full, fifo_empty;
  logic [EntW-1:0]   fifo_rd;
  logic [CntW-1:0]   fifo_count;
  logic [OutW-1:0]   outstanding;

  logic              err_q, stall_q;
  logic [31:0]       ld_count_q, st_count_q;

  // Requests are ignored entirely while reset is asserted.
  assign dual_req = req_mem_ld && req_mem_st && !rst;
  assign ld_acc   = req_mem_ld && !req_mem_st && !rst;
  assign st_acc   = req_mem_st && !req_mem_ld && !rst;

  assign word_idx = req_mem_addr[ADDR_W-1:3];
  assign addr_bad = (req_mem_addr[2:0] != 3'd0) ||
                    ({3'b000, word_idx} >= ADDR_W'(MEM_WORDS));

  // Combinational read: a load sees every store accepted at an earlier edge.
  assign ld_data = addr_bad ? '0 : mem[word_idx[IdxW-1:0]];

  always_ff @(posedge clk) begin
    if (st_acc && !addr_bad) mem[word_idx[IdxW-1:0]] <= req_mem_d_or_tag;
  end

  // Delay line payload needs no reset; only the valids matter.
  always_ff @(posedge clk) begin
    dl_ent_q[0] <= {req_mem_d_or_tag[TAG_W-1:0], ld_data};
    for (int i = 1; i < LATENCY; i++) dl_ent_q[i] <= dl_ent_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) dl_vld_q[i] <= 1'b0;
    end else begin
      dl_vld_q[0] <= ld_acc;
      for (int i = 1; i < LATENCY; i++) dl_vld_q[i] <= dl_vld_q[i-1];
    end
  end

  assign tail_vld = dl_vld_q[LATENCY-1];
  assign pop      = !fifo_empty && !rsp_mem_stall;
  // A full FIFO that is popping this cycle still has room for the arriving entry.
  assign fifo_wr  = tail_vld && (!fifo_full || pop);
  assign drop     = tail_vld && fifo_full && !pop;

  spmv_sync_fifo #(
    .WIDTH (EntW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (dl_ent_q[LATENCY-1]),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    outstanding = OutW'(fifo_count);
    for (int i = 0; i < LATENCY; i++) outstanding = outstanding + OutW'(dl_vld_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      ld_count_q <= '0;
      st_count_q <= '0;
    end else begin
      if (dual_req || ((ld_acc || st_acc) && addr_bad) || drop) err_q <= 1'b1;
      if (ld_acc) ld_count_q <= ld_count_q + 32'd1;
      if (st_acc) st_count_q <= st_count_q + 32'd1;
      stall_q <= (outstanding >= OutW'(RSP_DEPTH - STALL_MARGIN));
    end
  end

  assign rsp_mem_push  = pop;
  assign rsp_mem_tag   = pop ? fifo_rd[EntW-1:DATA_W] : '0;
  assign rsp_mem_q     = pop ? fifo_rd[DATA_W-1:0] : '0;
  assign req_mem_stall = stall_q;
  assign err           = err_q;
  assign ld_count      = ld_count_q;
  assign st_count      = st_count_q;

endmodule

// File: tb/tb_spmv_mem_model.sv
// Directed self-checking bench for spmv_mem_model with default parameters.
module tb_spmv_mem_model;

  localparam int unsigned Lat = 16;

  logic        clk;
  logic        rst;
  logic        req_mem_ld, req_mem_st;
  logic [47:0] req_mem_addr;
  logic [63:0] req_mem_d_or_tag;
  logic        req_mem_stall;
  logic        rsp_mem_push;
  logic [2:0]  rsp_mem_tag;
  logic [63:0] rsp_mem_q;
  logic        rsp_mem_stall;
  logic        err;
  logic [31:0] ld_count, st_count;

  int n_cmp;
  int n_bad;

  // Responses seen by run_collect: packed {tag, data} and cycle index.
  logic [66:0] rsp_ent[$];
  int          rsp_at[$];

  spmv_mem_model dut (
    .clk              (clk),
    .rst              (rst),
    .req_mem_ld       (req_mem_ld),
    .req_mem_st       (req_mem_st),
    .req_mem_addr     (req_mem_addr),
    .req_mem_d_or_tag (req_mem_d_or_tag),
    .req_mem_stall    (req_mem_stall),
    .rsp_mem_push     (rsp_mem_push),
    .rsp_mem_tag      (rsp_mem_tag),
    .rsp_mem_q        (rsp_mem_q),
    .rsp_mem_stall    (rsp_mem_stall),
    .err              (err),
    .ld_count         (ld_count),
    .st_count         (st_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_mem_ld       = 1'b0;
    req_mem_st       = 1'b0;
    req_mem_addr     = '0;
    req_mem_d_or_tag = '0;
  endtask

  task automatic set_ld(input int unsigned addr, input int unsigned tag);
    req_mem_ld       = 1'b1;
    req_mem_st       = 1'b0;
    req_mem_addr     = 48'(addr);
    req_mem_d_or_tag = 64'(tag);
  endtask

  task automatic do_st(input int unsigned addr, input logic [63:0] data);
    req_mem_ld       = 1'b0;
    req_mem_st       = 1'b1;
    req_mem_addr     = 48'(addr);
    req_mem_d_or_tag = data;
    step();
    idle();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Sample outputs mid-cycle for n cycles; index 0 is the cycle after the latest edge.
  task automatic run_collect(input int n);
    rsp_ent.delete();
    rsp_at.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rsp_mem_push) begin
        rsp_ent.push_back({rsp_mem_tag, rsp_mem_q});
        rsp_at.push_back(k);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          first_stall;
    int          n_push, first_push, last_push, order_bad;
    logic        stall_seen;
    logic [66:0] exp_ent;

    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    rsp_mem_stall = 1'b0;
    idle();
    repeat (3) step();

    // Reset state
    check_eq("rst_push",  96'(rsp_mem_push),  96'(0));
    check_eq("rst_stall", 96'(req_mem_stall), 96'(0));
    check_eq("rst_err",   96'(err),           96'(0));
    check_eq("rst_ldcnt", 96'(ld_count),      96'(0));
    check_eq("rst_stcnt", 96'(st_count),      96'(0));
    rst = 1'b0;

    // Single load: push appears exactly Lat edges after acceptance
    do_st(40, 64'h3FF0_0000_0000_0000);
    set_ld(40, 3);
    step();
    idle();
    repeat (Lat - 1) step();
    check_eq("single_early", 96'(rsp_mem_push), 96'(0));
    step();
    check_eq("single_push", 96'(rsp_mem_push), 96'(1));
    check_eq("single_rsp", 96'({rsp_mem_tag, rsp_mem_q}), 96'({3'd3, 64'h3FF0_0000_0000_0000}));
    step();
    check_eq("single_after", 96'(rsp_mem_push), 96'(0));
    check_eq("single_ldcnt", 96'(ld_count), 96'(1));

    // Store then load of the same word on the next cycle
    do_st(8, 64'hDEAD);
    set_ld(8, 1);
    step();
    idle();
    run_collect(24);
    check_eq("stld_count", 96'(rsp_ent.size()), 96'(1));
    if (rsp_ent.size() == 1) begin
      check_eq("stld_at",  96'(rsp_at[0]),  96'(Lat));
      check_eq("stld_rsp", 96'(rsp_ent[0]), 96'({3'd1, 64'hDEAD}));
    end
    check_eq("stld_stcnt", 96'(st_count), 96'(2));
    check_eq("stld_err",   96'(err),      96'(0));

    // Errors: dual request, misaligned load, out-of-range load
    req_mem_ld       = 1'b1;
    req_mem_st       = 1'b1;
    req_mem_addr     = 48'd16;
    req_mem_d_or_tag = 64'd2;
    step();
    idle();
    check_eq("dual_err",   96'(err),      96'(1));
    check_eq("dual_ldcnt", 96'(ld_count), 96'(2));
    check_eq("dual_stcnt", 96'(st_count), 96'(2));
    set_ld(12, 4);
    step();
    set_ld(4096 * 8, 5);
    step();
    idle();
    run_collect(24);
    check_eq("bad_count", 96'(rsp_ent.size()), 96'(2));
    if (rsp_ent.size() == 2) begin
      check_eq("misalign_rsp", 96'(rsp_ent[0]), 96'({3'd4, 64'd0}));
      check_eq("range_rsp",    96'(rsp_ent[1]), 96'({3'd5, 64'd0}));
    end
    check_eq("bad_ldcnt", 96'(ld_count), 96'(4));
    do_reset(1);
    check_eq("err_cleared", 96'(err), 96'(0));

    // Backpressure: 40 loads with the consumer stalled
    for (int i = 0; i < 40; i++) do_st(i * 8, 64'h1000 + 64'(i));
    rsp_mem_stall = 1'b1;
    first_stall   = -1;
    for (int i = 0; i < 40; i++) begin
      set_ld(i * 8, i % 8);
      step();
      if (req_mem_stall && first_stall < 0) first_stall = i;
    end
    idle();
    check_eq("bp_stall_rise", 96'(first_stall), 96'(28));
    repeat (25) step();
    check_eq("bp_err",      96'(err),           96'(1));
    check_eq("bp_stall_hi", 96'(req_mem_stall), 96'(1));
    check_eq("bp_no_push",  96'(rsp_mem_push),  96'(0));
    rsp_mem_stall = 1'b0;
    run_collect(40);
    check_eq("bp_count", 96'(rsp_ent.size()), 96'(32));
    for (int i = 0; i < rsp_ent.size() && i < 32; i++) begin
      exp_ent = {3'(i % 8), 64'h1000 + 64'(i)};
      check_eq($sformatf("bp_rsp%0d", i), 96'(rsp_ent[i]), 96'(exp_ent));
    end
    if (rsp_ent.size() == 32) check_eq("bp_last_at", 96'(rsp_at[31]), 96'(31));
    check_eq("bp_stall_lo", 96'(req_mem_stall), 96'(0));

    // Reset mid-flight: 5 loads, 3 idle cycles, reset with a load asserted
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      set_ld(i * 8, i);
      step();
    end
    idle();
    repeat (3) step();
    rst = 1'b1;
    set_ld(0, 7);
    step();
    rst = 1'b0;
    idle();
    run_collect(30);
    check_eq("rstmid_count", 96'(rsp_ent.size()), 96'(0));
    check_eq("rstmid_ldcnt", 96'(ld_count),       96'(0));
    check_eq("rstmid_stcnt", 96'(st_count),       96'(0));
    check_eq("rstmid_stall", 96'(req_mem_stall),  96'(0));
    set_ld(40, 6);
    step();
    idle();
    run_collect(24);
    check_eq("fresh_count", 96'(rsp_ent.size()), 96'(1));
    if (rsp_ent.size() == 1) begin
      check_eq("fresh_at",  96'(rsp_at[0]),  96'(Lat));
      check_eq("fresh_rsp", 96'(rsp_ent[0]), 96'({3'd6, 64'h1005}));
    end
    check_eq("fresh_ldcnt", 96'(ld_count), 96'(1));

    // Streaming: 1000 consecutive loads, no consumer stall
    n_push     = 0;
    first_push = -1;
    last_push  = -1;
    order_bad  = 0;
    stall_seen = 1'b0;
    for (int k = 0; k < 1030; k++) begin
      if (k < 1000) set_ld((k % 40) * 8, k % 8);
      else idle();
      @(negedge clk);
      if (req_mem_stall) stall_seen = 1'b1;
      if (rsp_mem_push) begin
        exp_ent = {3'(n_push % 8), 64'h1000 + 64'(n_push % 40)};
        if ({rsp_mem_tag, rsp_mem_q} !== exp_ent) order_bad++;
        if (first_push < 0) first_push = k;
        last_push = k;
        n_push++;
      end
      @(posedge clk);
      #1;
    end
    idle();
    check_eq("stream_count", 96'(n_push),     96'(1000));
    check_eq("stream_first", 96'(first_push), 96'(Lat + 1));
    check_eq("stream_last",  96'(last_push),  96'(Lat + 1000));
    check_eq("stream_order", 96'(order_bad),  96'(0));
    check_eq("stream_stall", 96'(stall_seen), 96'(0));
    check_eq("stream_ldcnt", 96'(ld_count),   96'(1001));
    check_eq("stream_err",   96'(err),        96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
